// File: rtl/vga_timing_tx_pkg.sv
// Shared VGA 640x480@60 timing defaults, colour type and the 8-entry palette.
// Imported by the timing top and the colour selector.
package vga_timing_tx_pkg;

    localparam int unsigned DEF_H_VIS = 640;
    localparam int unsigned DEF_H_FP  = 16;
    localparam int unsigned DEF_H_PW  = 96;
    localparam int unsigned DEF_H_BP  = 48;
    localparam int unsigned DEF_V_VIS = 480;
    localparam int unsigned DEF_V_FP  = 10;
    localparam int unsigned DEF_V_PW  = 2;
    localparam int unsigned DEF_V_BP  = 33;
    localparam int unsigned CNT_W     = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    function automatic rgb_t palette_lookup(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = 12'h000;
            3'd1:    c = 12'hF00;
            3'd2:    c = 12'h0F0;
            3'd3:    c = 12'h00F;
            3'd4:    c = 12'hFF0;
            3'd5:    c = 12'h0FF;
            3'd6:    c = 12'hF0F;
            3'd7:    c = 12'hFFF;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_tx_color_sel.sv
// Palette index selection: NEXT/PREV step a pending index at any clock,
// and the shown index only follows it at the frame-start strobe.
module vga_timing_tx_color_sel
    import vga_timing_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn_next,
    input  logic btn_prev,
    input  logic load,
    input  logic visible,
    output rgb_t rgb
);

    logic [2:0] pending_idx_r;
    logic [2:0] shown_idx_r;
    logic [2:0] lookup_idx_s;

    // Pending index accumulates button steps; shown index latches it once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_idx_r <= 3'd0;
            shown_idx_r   <= 3'd0;
        end else begin
            if (btn_next && !btn_prev) begin
                pending_idx_r <= pending_idx_r + 3'd1;
            end else if (btn_prev && !btn_next) begin
                pending_idx_r <= pending_idx_r - 3'd1;
            end else begin
                pending_idx_r <= pending_idx_r;
            end
            if (load) begin
                shown_idx_r <= pending_idx_r;
            end else begin
                shown_idx_r <= shown_idx_r;
            end
        end
    end

    // Pixel (0,0) is sampled on the load tick itself, so it must already see the new index.
    always_comb begin
        lookup_idx_s = shown_idx_r;
        rgb          = 12'h000;
        if (load) begin
            lookup_idx_s = pending_idx_r;
        end else begin
            lookup_idx_s = shown_idx_r;
        end
        if (visible) begin
            rgb = palette_lookup(lookup_idx_s);
        end else begin
            rgb = 12'h000;
        end
    end

endmodule

// File: rtl/vga_timing_tx.sv
// VGA transmitter: half-rate pixel tick, h/v counters, sync decode and
// registered pin drivers for a single frame-stable palette colour.
module vga_timing_tx
    import vga_timing_tx_pkg::*;
#(
    parameter int unsigned H_VIS = DEF_H_VIS,
    parameter int unsigned H_FP  = DEF_H_FP,
    parameter int unsigned H_PW  = DEF_H_PW,
    parameter int unsigned H_BP  = DEF_H_BP,
    parameter int unsigned V_VIS = DEF_V_VIS,
    parameter int unsigned V_FP  = DEF_V_FP,
    parameter int unsigned V_PW  = DEF_V_PW,
    parameter int unsigned V_BP  = DEF_V_BP
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic       BTN_NEXT,
    input  logic       BTN_PREV,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       VGA_HSYNC,
    output logic       VGA_VSYNC,
    output logic       FRAME
);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_VIS + H_FP + H_PW + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_VIS + V_FP + V_PW + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] H_SYNC_LO  = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_HI  = CNT_W'(H_VIS + H_FP + H_PW - 1);
    localparam logic [CNT_W-1:0] V_SYNC_LO  = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_HI  = CNT_W'(V_VIS + V_FP + V_PW - 1);

    logic             phase_r;
    logic             tick_s;
    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic             visible_s;
    logic             hsync_n_s;
    logic             vsync_n_s;
    logic             frame_start_s;
    rgb_t             rgb_s;
    rgb_t             rgb_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             frame_r;

    // Pixel-enable phase: first tick lands on the second clock after reset release.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            phase_r <= 1'b0;
        end else begin
            phase_r <= ~phase_r;
        end
    end

    assign tick_s = phase_r;

    // Horizontal and vertical position counters, advanced once per pixel tick.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (tick_s) begin
            if (h_cnt_r == H_LAST) begin
                h_cnt_r <= '0;
                if (v_cnt_r == V_LAST) begin
                    v_cnt_r <= '0;
                end else begin
                    v_cnt_r <= v_cnt_r + 10'd1;
                end
            end else begin
                h_cnt_r <= h_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r;
            v_cnt_r <= v_cnt_r;
        end
    end

    // Region and sync decode of the current counter position.
    always_comb begin
        visible_s     = (h_cnt_r < H_VIS_END) && (v_cnt_r < V_VIS_END);
        hsync_n_s     = !((h_cnt_r >= H_SYNC_LO) && (h_cnt_r <= H_SYNC_HI));
        vsync_n_s     = !((v_cnt_r >= V_SYNC_LO) && (v_cnt_r <= V_SYNC_HI));
        frame_start_s = tick_s && (h_cnt_r == '0) && (v_cnt_r == '0);
    end

    vga_timing_tx_color_sel u_color_sel (
        .clk      (CLK50MHZ),
        .rst      (RST),
        .btn_next (BTN_NEXT),
        .btn_prev (BTN_PREV),
        .load     (frame_start_s),
        .visible  (visible_s),
        .rgb      (rgb_s)
    );

    // Pin registers: sync and colour move together on the tick; FRAME is a single clock wide.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
            rgb_r   <= 12'h000;
            frame_r <= 1'b0;
        end else if (tick_s) begin
            hsync_r <= hsync_n_s;
            vsync_r <= vsync_n_s;
            rgb_r   <= rgb_s;
            frame_r <= frame_start_s;
        end else begin
            hsync_r <= hsync_r;
            vsync_r <= vsync_r;
            rgb_r   <= rgb_r;
            frame_r <= 1'b0;
        end
    end

    assign VGA_R     = rgb_r.r;
    assign VGA_G     = rgb_r.g;
    assign VGA_B     = rgb_r.b;
    assign VGA_HSYNC = hsync_r;
    assign VGA_VSYNC = vsync_r;
    assign FRAME     = frame_r;

endmodule

// File: tb/tb_vga_timing_tx.sv
// Randomised bench: a full-timing instance and a shrunken-timing instance
// share stimulus and are compared every clock against a pixel-arithmetic model.
module tb_vga_timing_tx;

    localparam int S_HV = 8, S_HF = 2, S_HP = 3, S_HB = 2;
    localparam int S_VV = 4, S_VF = 1, S_VP = 2, S_VB = 2;
    localparam int F_HV = 640, F_HF = 16, F_HP = 96, F_HB = 48;
    localparam int F_VV = 480, F_VF = 10, F_VP = 2, F_VB = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_next = 1'b0;
    logic btn_prev = 1'b0;

    logic [3:0] f_r, f_g, f_b, s_r, s_g, s_b;
    logic       f_hs, f_vs, f_fr, s_hs, s_vs, s_fr;

    logic [11:0] pal [8] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
                             12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};

    int checks = 0;
    int errors = 0;
    int k = 0;
    logic [2:0] pend = 3'd0;
    logic [2:0] shown_f = 3'd0;
    logic [2:0] shown_s = 3'd0;

    always #10 clk = ~clk;

    vga_timing_tx dut_full (
        .CLK50MHZ (clk), .RST (rst), .BTN_NEXT (btn_next), .BTN_PREV (btn_prev),
        .VGA_R (f_r), .VGA_G (f_g), .VGA_B (f_b),
        .VGA_HSYNC (f_hs), .VGA_VSYNC (f_vs), .FRAME (f_fr)
    );

    vga_timing_tx #(
        .H_VIS (S_HV), .H_FP (S_HF), .H_PW (S_HP), .H_BP (S_HB),
        .V_VIS (S_VV), .V_FP (S_VF), .V_PW (S_VP), .V_BP (S_VB)
    ) dut_small (
        .CLK50MHZ (clk), .RST (rst), .BTN_NEXT (btn_next), .BTN_PREV (btn_prev),
        .VGA_R (s_r), .VGA_G (s_g), .VGA_B (s_b),
        .VGA_HSYNC (s_hs), .VGA_VSYNC (s_vs), .FRAME (s_fr)
    );

    task automatic check_eq(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got hs,vs,fr,rgb=%b,%b,%b,%h expected %b,%b,%b,%h",
                     tag, k, obs[14], obs[13], obs[12], obs[11:0],
                     exp[14], exp[13], exp[12], exp[11:0]);
        end
    endtask

    // k = clock edges seen since reset release; pixel ticks fall on even k.
    function automatic logic [14:0] ref_out(input int kk, input int hv, input int hf, input int hp,
                                            input int hb, input int vv, input int vf, input int vp,
                                            input int vb, input logic [2:0] idx);
        int ht, vt, p, h, v;
        logic hs, vs, fr;
        logic [11:0] c;
        if (kk < 2) return {1'b1, 1'b1, 1'b0, 12'h000};
        ht = hv + hf + hp + hb;
        vt = vv + vf + vp + vb;
        p  = kk / 2 - 1;
        h  = p % ht;
        v  = (p / ht) % vt;
        hs = !(h >= hv + hf && h < hv + hf + hp);
        vs = !(v >= vv + vf && v < vv + vf + vp);
        fr = (kk % 2 == 0) && h == 0 && v == 0;
        c  = (h < hv && v < vv) ? pal[idx] : 12'h000;
        return {hs, vs, fr, c};
    endfunction

    function automatic bit frame_edge(input int kk, input int hv, input int hf, input int hp,
                                      input int hb, input int vv, input int vf, input int vp,
                                      input int vb);
        int tot;
        tot = (hv + hf + hp + hb) * (vv + vf + vp + vb);
        return (kk >= 2) && (kk % 2 == 0) && ((kk / 2 - 1) % tot == 0);
    endfunction

    task automatic cycle(input logic r, input logic n, input logic p);
        rst      = r;
        btn_next = n;
        btn_prev = p;
        @(posedge clk);
        if (r) begin
            k = 0; pend = 3'd0; shown_f = 3'd0; shown_s = 3'd0;
        end else begin
            k++;
            if (frame_edge(k, F_HV, F_HF, F_HP, F_HB, F_VV, F_VF, F_VP, F_VB)) shown_f = pend;
            if (frame_edge(k, S_HV, S_HF, S_HP, S_HB, S_VV, S_VF, S_VP, S_VB)) shown_s = pend;
            if (n && !p) pend = pend + 3'd1;
            else if (p && !n) pend = pend - 3'd1;
        end
        @(negedge clk);
        check_eq("full", {f_hs, f_vs, f_fr, f_r, f_g, f_b},
                 ref_out(k, F_HV, F_HF, F_HP, F_HB, F_VV, F_VF, F_VP, F_VB, shown_f));
        check_eq("small", {s_hs, s_vs, s_fr, s_r, s_g, s_b},
                 ref_out(k, S_HV, S_HF, S_HP, S_HB, S_VV, S_VF, S_VP, S_VB, shown_s));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        // Three full-timing lines with sync pulses; many small frames at index 0.
        idle(5000);
        // PREV from 0 wraps to 7, then NEXT from 7 wraps to 0.
        cycle(1'b0, 1'b0, 1'b1);
        idle(600);
        cycle(1'b0, 1'b1, 1'b0);
        idle(600);
        // Simultaneous NEXT and PREV leave the index alone.
        cycle(1'b0, 1'b1, 1'b1);
        idle(600);
        // Three NEXT pulses inside one frame, then watch the next frame boundary.
        cycle(1'b0, 1'b1, 1'b0);
        idle(3);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        idle(600);
        // Reset mid-line on the full-timing instance, then restart from (0,0).
        cycle(1'b1, 1'b1, 1'b0);
        idle(600);
        cycle(1'b1, 1'b0, 1'b0);
        idle(1700);
        // Random button pulses with occasional resets.
        for (int i = 0; i < 9000; i++) begin
            cycle(($urandom_range(0, 2999) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
        end
        idle(300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
